regfile_multiport: RTL and testbench
====================================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter WIDTH, default `WORD, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (power of two, 4..64).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, 1 = address DEPTH-1 is hardwired zero (XZR).
REQ-005 SHALL derive localparam AW = $clog2(DEPTH).
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port regWrite  input  1  write enable.
REQ-009 SHALL have port write_reg  input  AW  write address.
REQ-010 SHALL have port write_data  input  WIDTH  write data.
REQ-011 SHALL have port rd_en  input  1  read request for all ports.
REQ-012 SHALL have port read_reg  input  NUM_RD*AW  packed read addresses, port k at [k*AW +: AW].
REQ-013 SHALL have port read_data  output  NUM_RD*WIDTH  packed registered read data, port k at [k*WIDTH +: WIDTH].
REQ-014 SHALL have port read_valid  output  1  read_data is valid this cycle.
REQ-015 SHALL have port init_busy  output  1  array clear in progress.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR, READY.
REQ-017 In CLEAR, SHALL write zero to entry clr_cnt each cycle, clr_cnt counting 0..DEPTH-1; at DEPTH-1, SHALL go to READY the next cycle.
REQ-018 init_busy SHALL be 1 exactly while in CLEAR, i.e. DEPTH cycles after reset release.
REQ-019 In CLEAR, regWrite SHALL be ignored (no array update).
REQ-020 In CLEAR, rd_en SHALL be ignored: read_valid stays 0 and read_data holds its value.
REQ-021 In READY, regWrite=1 SHALL update entry write_reg at the clock edge, except when ZERO_REG=1 and write_reg=DEPTH-1 (dropped).
REQ-022 In READY, rd_en=1 SHALL register all NUM_RD ports; read_data is valid one cycle later, with read_valid=1 for that one cycle.
REQ-023 When rd_en=0, read_data SHALL hold its value and read_valid SHALL be 0.
REQ-024 Same-cycle write and read of one address SHALL return write_data (write-first bypass), per port independently.
REQ-025 With ZERO_REG=1, reads of address DEPTH-1 SHALL return 0 regardless of a bypass condition.
REQ-026 Several ports reading the same address SHALL each return identical data.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=CLEAR, clr_cnt=0, read_data=0, read_valid=0, init_busy=1.
REQ-028 Reset asserted mid-CLEAR or mid-operation SHALL restart the full clear sweep after release.
REQ-029 Array contents SHALL NOT be reset asynchronously; only the sweep zeroes them.

Structure
REQ-030 `WORD and the default DEPTH SHALL come from definitions.vh; no new shared constants.
REQ-031 The clear FSM with clr_cnt SHALL be one sub-module, regfile_clear_ctrl, outputting clr_we, clr_addr and init_busy.
REQ-032 Read ports SHALL be built with a generate loop over NUM_RD.

Verification
REQ-033 Release reset -> init_busy=1 for exactly 32 cycles; then reads of all 32 addresses return 0.
REQ-034 Write 0x1234 to r5, then next cycle rd_en with port0=r5, port1=r5 -> one cycle later both ports read 0x1234, read_valid=1.
REQ-035 Same cycle: write 0xDEAD to r7 and read r7 -> next cycle read_data=0xDEAD.
REQ-036 Write 0xFFFF to r31 with ZERO_REG=1, then read r31 (including same-cycle bypass) -> read_data=0.
REQ-037 Assert rst_n=0 at clear cycle 10, release -> init_busy=1 for 32 full cycles; regWrite during CLEAR has no effect (later read returns 0).
REQ-038 Rerun REQ-033/034 with WIDTH=32, DEPTH=16, NUM_RD=3 -> 16-cycle clear, third port correct.

Source files
------------

// File: rtl/regfile_multiport_pkg.sv
// Types shared by the multi-port register file and its clear controller.
`include "definitions.vh"

package regfile_multiport_pkg;

   typedef enum logic {
      StClear = 1'b0,
      StReady = 1'b1
   } clr_state_e;

endpackage

// File: rtl/definitions.vh
// Shared project-wide macros: default datapath word size and register count.
`ifndef DEFINITIONS_VH
`define DEFINITIONS_VH
`define WORD 16
`define REGFILE_DEPTH 32
`endif

// File: rtl/regfile_clear_ctrl.sv
// Post-reset sweep controller: zeroes one entry per cycle, then hands the array over.
module regfile_clear_ctrl
   import regfile_multiport_pkg::*;
#(
   parameter  int unsigned DEPTH = 32,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          o_clr_we,
   output logic [AW-1:0] o_clr_addr,
   output logic          o_init_busy
);

   localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

   clr_state_e    r_state;
   clr_state_e    w_state_next;
   logic [AW-1:0] r_clr_cnt;
   logic [AW-1:0] w_clr_cnt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StClear;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_clr_cnt <= w_clr_cnt_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_clr_cnt_next = r_clr_cnt;
      unique case (r_state)
         StClear: begin
            w_clr_cnt_next = r_clr_cnt + 1'b1;
            if (r_clr_cnt == LastAddr) begin
               w_state_next   = StReady;
               w_clr_cnt_next = '0;
            end
         end
         StReady: w_state_next = StReady;
         default: w_state_next = StClear;
      endcase
   end

   always_comb begin
      o_clr_we    = (r_state == StClear);
      o_init_busy = (r_state == StClear);
      o_clr_addr  = r_clr_cnt;
   end

endmodule

// File: rtl/regfile_multiport.sv
// Register file with one write port, NUM_RD registered read ports, write-first
// bypass and an optional hardwired-zero top register.
`include "definitions.vh"

module regfile_multiport
   import regfile_multiport_pkg::*;
#(
   parameter  int unsigned WIDTH    = `WORD,
   parameter  int unsigned DEPTH    = `REGFILE_DEPTH,
   parameter  int unsigned NUM_RD   = 2,
   parameter  int unsigned ZERO_REG = 1,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    regWrite,
   input  logic [AW-1:0]           write_reg,
   input  logic [WIDTH-1:0]        write_data,
   input  logic                    rd_en,
   input  logic [NUM_RD*AW-1:0]    read_reg,
   output logic [NUM_RD*WIDTH-1:0] read_data,
   output logic                    read_valid,
   output logic                    init_busy
);

   localparam logic [AW-1:0] ZeroAddr = AW'(DEPTH - 1);
   localparam logic          ZeroEn   = (ZERO_REG != 0);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_clr_we;
   logic [AW-1:0]    w_clr_addr;
   logic             w_busy;
   logic             w_wr_fire;
   logic             w_rd_fire;
   logic             r_read_valid;

   regfile_clear_ctrl #(
      .DEPTH (DEPTH)
   ) u_clear_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .o_clr_we    (w_clr_we),
      .o_clr_addr  (w_clr_addr),
      .o_init_busy (w_busy)
   );

   // Writes to the zero register are dropped so the array entry itself stays 0.
   assign w_wr_fire = regWrite && !w_busy && !(ZeroEn && (write_reg == ZeroAddr));
   assign w_rd_fire = rd_en && !w_busy;

   // No reset on the array: only the clear sweep zeroes it.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[w_clr_addr] <= '0;
      end else if (w_wr_fire) begin
         r_mem[write_reg] <= write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_read_valid <= 1'b0;
      end else begin
         r_read_valid <= w_rd_fire;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0]    w_addr;
      logic [WIDTH-1:0] w_data;
      logic [WIDTH-1:0] r_data;

      assign w_addr = read_reg[k*AW +: AW];

      always_comb begin
         if (ZeroEn && (w_addr == ZeroAddr)) begin
            w_data = '0;
         end else if (w_wr_fire && (write_reg == w_addr)) begin
            w_data = write_data;
         end else begin
            w_data = r_mem[w_addr];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_data <= '0;
         end else if (w_rd_fire) begin
            r_data <= w_data;
         end
      end

      assign read_data[k*WIDTH +: WIDTH] = r_data;
   end

   assign read_valid = r_read_valid;
   assign init_busy  = w_busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: default 16x32 two-port file plus a 32-bit 16-entry three-port file.
module tb_regfile_multiport;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WIDTH=16, DEPTH=32, NUM_RD=2, ZERO_REG=1
   logic        rst_a, we_a, rd_a, rv_a, busy_a;
   logic [4:0]  wa_a;
   logic [15:0] wd_a;
   logic [9:0]  ra_a;
   logic [31:0] rdata_a;

   // Instance B: WIDTH=32, DEPTH=16, NUM_RD=3, ZERO_REG=1
   logic        rst_b, we_b, rd_b, rv_b, busy_b;
   logic [3:0]  wa_b;
   logic [31:0] wd_b;
   logic [11:0] ra_b;
   logic [95:0] rdata_b;

   regfile_multiport #(
      .WIDTH    (16),
      .DEPTH    (32),
      .NUM_RD   (2),
      .ZERO_REG (1)
   ) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_a),
      .regWrite   (we_a),
      .write_reg  (wa_a),
      .write_data (wd_a),
      .rd_en      (rd_a),
      .read_reg   (ra_a),
      .read_data  (rdata_a),
      .read_valid (rv_a),
      .init_busy  (busy_a)
   );

   regfile_multiport #(
      .WIDTH    (32),
      .DEPTH    (16),
      .NUM_RD   (3),
      .ZERO_REG (1)
   ) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_b),
      .regWrite   (we_b),
      .write_reg  (wa_b),
      .write_data (wd_b),
      .rd_en      (rd_b),
      .read_reg   (ra_b),
      .read_data  (rdata_b),
      .read_valid (rv_b),
      .init_busy  (busy_b)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference contents of instance A, as the specification defines them.
   logic [15:0] mem_m [32];

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [15:0] wd;
      logic        rd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [15:0] e0;
      logic [15:0] e1;
      logic        ev;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle of A in READY and tracks the write in the reference model.
   task automatic drive_a(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                          input logic rd, input logic [4:0] r0, input logic [4:0] r1);
      we_a = we;
      wa_a = wa;
      wd_a = wd;
      rd_a = rd;
      ra_a = {r1, r0};
      step();
      if (we && wa != 5'd31) mem_m[wa] = wd;
   endtask

   function automatic logic [15:0] exp_rd_a(input logic we, input logic [4:0] wa,
                                            input logic [15:0] wd, input logic [4:0] ra);
      if (ra == 5'd31) return 16'h0;
      if (we && wa == ra) return wd;
      return mem_m[ra];
   endfunction

   task automatic drive_b(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                          input logic rd, input logic [3:0] r0, input logic [3:0] r1,
                          input logic [3:0] r2);
      we_b = we;
      wa_b = wa;
      wd_b = wd;
      rd_b = rd;
      ra_b = {r2, r1, r0};
      step();
   endtask

   initial begin
      int          cyc;
      logic        rv_seen;
      logic [15:0] e0, e1;
      logic        we, rd;
      logic [4:0]  wa, r0, r1;
      logic [15:0] wd;

      rst_a = 1'b0; we_a = 1'b0; wa_a = '0; wd_a = '0; rd_a = 1'b0; ra_a = '0;
      rst_b = 1'b0; we_b = 1'b0; wa_b = '0; wd_b = '0; rd_b = 1'b0; ra_b = '0;
      for (int i = 0; i < 32; i++) mem_m[i] = '0;

      tbl[0] = '{1'b1, 5'd5,  16'h1234, 1'b0, 5'd0,  5'd0,  16'h0000, 16'h0000, 1'b0};
      tbl[1] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd5,  5'd5,  16'h1234, 16'h1234, 1'b1};
      tbl[2] = '{1'b1, 5'd7,  16'hDEAD, 1'b1, 5'd7,  5'd5,  16'hDEAD, 16'h1234, 1'b1};
      tbl[3] = '{1'b1, 5'd31, 16'hFFFF, 1'b1, 5'd31, 5'd7,  16'h0000, 16'hDEAD, 1'b1};
      tbl[4] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd31, 5'd31, 16'h0000, 16'h0000, 1'b1};
      tbl[5] = '{1'b0, 5'd0,  16'h0000, 1'b0, 5'd5,  5'd7,  16'h0000, 16'h0000, 1'b0};
      tbl[6] = '{1'b1, 5'd3,  16'hAAAA, 1'b1, 5'd3,  5'd7,  16'hAAAA, 16'hDEAD, 1'b1};
      tbl[7] = '{1'b1, 5'd3,  16'h5555, 1'b0, 5'd0,  5'd0,  16'hAAAA, 16'hDEAD, 1'b0};
      tbl[8] = '{1'b0, 5'd0,  16'h0000, 1'b1, 5'd2,  5'd3,  16'h0000, 16'h5555, 1'b1};

      // Reset state
      step();
      chk("a_rst_busy", 64'(busy_a), 64'd1);
      chk("a_rst_valid", 64'(rv_a), 64'd0);
      chk("a_rst_data", 64'(rdata_a), 64'd0);

      // Clear sweep length
      rst_a = 1'b1;
      cyc = 0;
      while (busy_a && cyc < 100) begin
         step();
         cyc++;
      end
      chk("a_clear_cycles", 64'(cyc), 64'd32);

      for (int i = 0; i < 32; i++) begin
         drive_a(1'b0, 5'd0, 16'h0, 1'b1, 5'(i), 5'(31 - i));
         chk("a_zero_rd_valid", 64'(rv_a), 64'd1);
         chk("a_zero_rd_p0", 64'(rdata_a[15:0]), 64'd0);
         chk("a_zero_rd_p1", 64'(rdata_a[31:16]), 64'd0);
      end

      for (int i = 0; i < 9; i++) begin
         drive_a(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra0, tbl[i].ra1);
         chk("a_tbl_valid", 64'(rv_a), 64'(tbl[i].ev));
         chk("a_tbl_p0", 64'(rdata_a[15:0]), 64'(tbl[i].e0));
         chk("a_tbl_p1", 64'(rdata_a[31:16]), 64'(tbl[i].e1));
      end

      // Randomized traffic against the reference model
      e0 = rdata_a[15:0];
      e1 = rdata_a[31:16];
      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 3) != 0);
         wa = 5'($urandom_range(0, 31));
         wd = 16'($urandom);
         r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 31));
         if (rd) begin
            e0 = exp_rd_a(we, wa, wd, r0);
            e1 = exp_rd_a(we, wa, wd, r1);
         end
         drive_a(we, wa, wd, rd, r0, r1);
         chk("a_rnd_valid", 64'(rv_a), 64'(rd));
         chk("a_rnd_p0", 64'(rdata_a[15:0]), 64'(e0));
         chk("a_rnd_p1", 64'(rdata_a[31:16]), 64'(e1));
      end

      // Asynchronous reset mid-operation clears outputs immediately
      drive_a(1'b1, 5'd4, 16'h4444, 1'b1, 5'd4, 5'd4);
      chk("a_pre_rst_data", 64'(rdata_a), 64'h4444_4444);
      #2 rst_a = 1'b0;
      #1;
      chk("a_async_rst_data", 64'(rdata_a), 64'd0);
      chk("a_async_rst_busy", 64'(busy_a), 64'd1);
      chk("a_async_rst_valid", 64'(rv_a), 64'd0);
      step();
      rst_a = 1'b1;
      we_a = 1'b1; wa_a = 5'd9; wd_a = 16'hBEEF; rd_a = 1'b1; ra_a = {5'd4, 5'd9};
      for (int i = 0; i < 10; i++) step();

      // Reset again at clear cycle 10; the full sweep must restart
      rst_a = 1'b0;
      #1;
      chk("a_rst10_busy", 64'(busy_a), 64'd1);
      step();
      rst_a = 1'b1;
      cyc = 0;
      rv_seen = 1'b0;
      while (busy_a && cyc < 100) begin
         step();
         cyc++;
         if (rv_a) rv_seen = 1'b1;
      end
      chk("a_reclear_cycles", 64'(cyc), 64'd32);
      chk("a_clear_rd_ignored", 64'(rv_seen), 64'd0);
      for (int i = 0; i < 32; i++) mem_m[i] = '0;
      drive_a(1'b0, 5'd0, 16'h0, 1'b1, 5'd9, 5'd4);
      chk("a_clear_wr_ignored", 64'(rdata_a), 64'd0);
      chk("a_post_clear_valid", 64'(rv_a), 64'd1);
      drive_a(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'd0);
      chk("a_idle_valid", 64'(rv_a), 64'd0);

      // Instance B: 16-entry, 32-bit, three read ports
      chk("b_rst_busy", 64'(busy_b), 64'd1);
      rst_b = 1'b1;
      cyc = 0;
      while (busy_b && cyc < 100) begin
         step();
         cyc++;
      end
      chk("b_clear_cycles", 64'(cyc), 64'd16);
      for (int i = 0; i < 16; i++) begin
         drive_b(1'b0, 4'd0, 32'h0, 1'b1, 4'(i), 4'(15 - i), 4'(i ^ 5));
         chk("b_zero_rd", 64'(rdata_b[63:0]) | 64'(rdata_b[95:64]), 64'd0);
         chk("b_zero_valid", 64'(rv_b), 64'd1);
      end
      drive_b(1'b1, 4'd5, 32'h0000_1234, 1'b0, 4'd0, 4'd0, 4'd0);
      chk("b_wr_valid", 64'(rv_b), 64'd0);
      drive_b(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 4'd5, 4'd5);
      chk("b_p0", 64'(rdata_b[31:0]), 64'h1234);
      chk("b_p1", 64'(rdata_b[63:32]), 64'h1234);
      chk("b_p2", 64'(rdata_b[95:64]), 64'h1234);
      chk("b_valid", 64'(rv_b), 64'd1);
      drive_b(1'b1, 4'd2, 32'hCAFE_BABE, 1'b1, 4'd2, 4'd5, 4'd15);
      chk("b_byp_p0", 64'(rdata_b[31:0]), 64'hCAFE_BABE);
      chk("b_byp_p1", 64'(rdata_b[63:32]), 64'h1234);
      chk("b_byp_p2", 64'(rdata_b[95:64]), 64'd0);
      drive_b(1'b1, 4'd15, 32'hFFFF_FFFF, 1'b1, 4'd15, 4'd15, 4'd2);
      chk("b_zr_p0", 64'(rdata_b[31:0]), 64'd0);
      chk("b_zr_p1", 64'(rdata_b[63:32]), 64'd0);
      chk("b_zr_p2", 64'(rdata_b[95:64]), 64'hCAFE_BABE);
      drive_b(1'b0, 4'd0, 32'h0, 1'b1, 4'd15, 4'd2, 4'd2);
      chk("b_zr_stay", 64'(rdata_b[31:0]), 64'd0);
      chk("b_p2_again", 64'(rdata_b[95:64]), 64'hCAFE_BABE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
